// File: rtl/i2s_pkg.sv
// Shared types for the I2S slave receiver: receiver state and LRCLK channel encoding.
package i2s_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync.sv
// Single-bit multi-flop synchronizer bringing an asynchronous serial line into clk_i.
module i2s_sync #(
    parameter int sync_depth_p = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic [sync_depth_p-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[sync_depth_p-2:0], d_i};
        end
    end

    assign q_o = sync_q[sync_depth_p-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA, assembles left/right words and
// presents complete stereo frames on a valid/ready stream.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int width_p      = 24,
    parameter int sync_depth_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               bclk_i,
    input  logic               lrclk_i,
    input  logic               sdata_i,
    output logic [width_p-1:0] data_l_o,
    output logic [width_p-1:0] data_r_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               locked_o,
    output logic               overrun_o
);

    localparam int CW = $clog2(width_p + 1);
    localparam logic [CW-1:0] FULL_C = CW'(width_p);

    logic bclk_s, lrclk_s, sdata_s;
    logic bclk_hist_q;
    logic bclk_rise;

    state_e             state_q, state_d;
    logic               lr_prev_q, lr_prev_d;
    logic [width_p-1:0] shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [width_p-1:0] shift_in;
    logic [CW-1:0]      cnt_in;
    logic               word_vld_q, word_vld_d;
    logic               word_lr_q, word_lr_d;
    logic [width_p-1:0] word_q, word_d;
    logic [width_p-1:0] left_q, left_d;
    logic               have_left_q, have_left_d;
    logic               emit;
    logic [width_p-1:0] data_l_q, data_l_d;
    logic [width_p-1:0] data_r_q, data_r_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    i2s_sync #(.sync_depth_p(sync_depth_p)) u_sync_bclk (
        .clk_i(clk_i), .reset_ni(reset_ni), .d_i(bclk_i), .q_o(bclk_s)
    );
    i2s_sync #(.sync_depth_p(sync_depth_p)) u_sync_lrclk (
        .clk_i(clk_i), .reset_ni(reset_ni), .d_i(lrclk_i), .q_o(lrclk_s)
    );
    i2s_sync #(.sync_depth_p(sync_depth_p)) u_sync_sdata (
        .clk_i(clk_i), .reset_ni(reset_ni), .d_i(sdata_i), .q_o(sdata_s)
    );

    assign bclk_rise = bclk_s & ~bclk_hist_q;

    // Capture: the bit at each BCLK rise belongs to the previous slot (I2S one-bit delay),
    // so it is shifted in before a slot boundary commits the word.
    always_comb begin
        state_d    = state_q;
        lr_prev_d  = lr_prev_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word_vld_d = 1'b0;
        word_lr_d  = word_lr_q;
        word_d     = word_q;
        shift_in   = shift_q;
        cnt_in     = cnt_q;
        if (cnt_q < FULL_C) begin
            shift_in = {shift_q[width_p-2:0], sdata_s};
            cnt_in   = cnt_q + CW'(1);
        end
        if (bclk_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_in;
            if (lrclk_s != lr_prev_q) begin
                word_d     = shift_in << (FULL_C - cnt_in);
                word_lr_d  = lr_prev_q;
                word_vld_d = (state_q == RUN);
                shift_d    = '0;
                cnt_d      = '0;
                lr_prev_d  = lrclk_s;
                state_d    = RUN;
            end
        end
    end

    // Pairing and output stream, one cycle after the commit.
    always_comb begin
        left_d      = left_q;
        have_left_d = have_left_q;
        emit        = 1'b0;
        if (word_vld_q) begin
            if (word_lr_q == LR_LEFT) begin
                left_d      = word_q;
                have_left_d = 1'b1;
            end else if (have_left_q) begin
                emit        = 1'b1;
                have_left_d = 1'b0;
            end
        end

        data_l_d  = data_l_q;
        data_r_d  = data_r_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (emit) begin
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end else begin
                data_l_d = left_q;
                data_r_d = word_q;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            bclk_hist_q <= 1'b0;
            state_q     <= SYNC;
            lr_prev_q   <= LR_LEFT;
            shift_q     <= '0;
            cnt_q       <= '0;
            word_vld_q  <= 1'b0;
            word_lr_q   <= LR_LEFT;
            word_q      <= '0;
            left_q      <= '0;
            have_left_q <= 1'b0;
            data_l_q    <= '0;
            data_r_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bclk_hist_q <= bclk_s;
            state_q     <= state_d;
            lr_prev_q   <= lr_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            word_vld_q  <= word_vld_d;
            word_lr_q   <= word_lr_d;
            word_q      <= word_d;
            left_q      <= left_d;
            have_left_q <= have_left_d;
            data_l_q    <= data_l_d;
            data_r_q    <= data_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_l_o  = data_l_q;
    assign data_r_o  = data_r_q;
    assign valid_o   = valid_q;
    assign locked_o  = (state_q == RUN);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: an I2S master BFM (bclk = clk/8) drives slots; frames seen on the
// output stream are compared against constants and a bit-level reference model.
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int W  = 24;
    localparam int SD = 2;

    logic         clk, reset_n, bclk, lrclk, sdata, ready;
    logic [W-1:0] data_l, data_r;
    logic         valid, locked, overrun;

    i2s_rx #(.width_p(W), .sync_depth_p(SD)) dut (
        .clk_i(clk), .reset_ni(reset_n), .bclk_i(bclk), .lrclk_i(lrclk), .sdata_i(sdata),
        .data_l_o(data_l), .data_r_o(data_r), .valid_o(valid), .ready_i(ready),
        .locked_o(locked), .overrun_o(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          n;
        logic [W-1:0] el;
        logic [W-1:0] er;
    } vec_t;

    vec_t           tbl[6];
    int             n_vec = 0;
    int             n_err = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] obs_q[$];
    logic           rnd_ready = 1'b0;

    logic           pending, line_lr, flushed;
    logic           m_prev, m_locked, m_have;
    logic [W-1:0]   m_acc, m_left;
    int             m_cnt;

    always @(negedge clk) if (valid && ready) obs_q.push_back({data_l, data_r});

    always @(posedge clk) if (rnd_ready) begin
        #1;
        ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input int idx, input logic [W-1:0] l, input logic [W-1:0] r);
        logic [2*W-1:0] act;
        act = (idx < obs_q.size()) ? obs_q[idx] : 'x;
        chk(name, act, {l, r});
    endtask

    task automatic wait_obs(input int n, input string name);
        int c = 0;
        while (obs_q.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(name, 48'(obs_q.size()), 48'(n));
    endtask

    // Reference: every bit at a BCLK rise is owned by the slot LRCLK had at the previous rise.
    task automatic model_reset();
        m_prev = LR_LEFT; m_locked = 1'b0; m_have = 1'b0;
        m_acc = '0; m_left = '0; m_cnt = 0;
    endtask

    task automatic model_sample(input logic lr, input logic d);
        logic [W-1:0] word;
        if (m_cnt < W) begin
            m_acc[W-1-m_cnt] = d;
            m_cnt++;
        end
        if (lr != m_prev) begin
            word = m_acc; m_acc = '0; m_cnt = 0;
            if (!m_locked) m_locked = 1'b1;
            else if (m_prev == LR_LEFT) begin m_left = word; m_have = 1'b1; end
            else if (m_have) begin exp_q.push_back({m_left, word}); m_have = 1'b0; end
            m_prev = lr;
        end
    endtask

    task automatic do_reset(input bit check);
        bclk = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #30;
        reset_n = 1'b1;
        #10;
        exp_q.delete();
        obs_q.delete();
        if (check) begin
            chk("rst_data_l", 48'(data_l), 48'h0);
            chk("rst_data_r", 48'(data_r), 48'h0);
            chk("rst_valid", 48'(valid), 48'h0);
            chk("rst_locked", 48'(locked), 48'h0);
            chk("rst_overrun", 48'(overrun), 48'h0);
        end
    endtask

    // mode 1: latency probe on this bit; mode 2: ready pulse in the emit cycle.
    task automatic send_bit(input logic lr, input logic d, input int mode);
        time t_rise;
        bclk = 1'b0; lrclk = lr; sdata = d; line_lr = lr;
        #40;
        bclk = 1'b1;
        t_rise = $time;
        model_sample(lr, d);
        if (mode == 1) begin
            repeat (SD + 1) @(posedge clk);
            #1 chk("latency_before", 48'(valid), 48'h0);
            @(posedge clk);
            #1 chk("latency_at", 48'(valid), 48'h1);
        end else if (mode == 2) begin
            repeat (SD + 1) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
        end
        #(40 - ($time - t_rise));
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] val, input int n, input int rst_at);
        int start;
        start = (flushed && lr == line_lr) ? 1 : 0;
        flushed = 1'b0;
        for (int j = start; j < n; j++) begin
            send_bit(lr, (j == 0) ? pending : val[32-j], 0);
            if (j == rst_at) do_reset(1);
        end
        pending = val[32-n];
    endtask

    task automatic flush(input int mode);
        send_bit(LR_LEFT, pending, mode);
        flushed = 1'b1;
    endtask

    task automatic align();
        @(negedge clk);
        #3;
    endtask

    initial begin
        tbl[0] = '{32'hA5A5A500, 32'h5A5A5A00, 32, 24'hA5A5A5, 24'h5A5A5A};
        tbl[1] = '{32'h80010000, 32'h7FFE0000, 16, 24'h800100, 24'h7FFE00};
        tbl[2] = '{32'h12345600, 32'hFEDCBA00, 24, 24'h123456, 24'hFEDCBA};
        tbl[3] = '{32'hFFFFFFFF, 32'h000000FF, 32, 24'hFFFFFF, 24'h000000};
        tbl[4] = '{32'hC3000000, 32'h3C000000, 8,  24'hC30000, 24'h3C0000};
        tbl[5] = '{32'hABC00000, 32'h00100000, 12, 24'hABC000, 24'h001000};

        reset_n = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; ready = 1'b1;
        pending = 1'b0; line_lr = LR_LEFT; flushed = 1'b0;
        model_reset();
        #3;
        do_reset(1);

        // Table: warm-up frame is discarded, then every entry must appear in order.
        send_slot(LR_LEFT, tbl[0].l, 32, -1);
        chk("locked_before_edge", 48'(locked), 48'h0);
        send_slot(LR_RIGHT, tbl[0].r, 32, -1);
        chk("locked_after_edge", 48'(locked), 48'h1);
        chk("warmup_no_frame", 48'(obs_q.size()), 48'h0);
        for (int i = 0; i < 6; i++) begin
            send_slot(LR_LEFT, tbl[i].l, tbl[i].n, -1);
            send_slot(LR_RIGHT, tbl[i].r, tbl[i].n, -1);
        end
        flush(0);
        wait_obs(6, "tbl_count");
        for (int i = 0; i < 6; i++) chk_frame($sformatf("tbl_frame%0d", i), i, tbl[i].el, tbl[i].er);

        // Latency from the BCLK edge carrying the right LSB.
        align();
        obs_q.delete();
        send_slot(LR_LEFT, 32'h11111100, 24, -1);
        send_slot(LR_RIGHT, 32'h22222200, 24, -1);
        flush(1);
        wait_obs(1, "lat_count");
        chk_frame("lat_frame", 0, 24'h111111, 24'h222222);

        // Backpressure across two frames: second frame dropped, overrun sticky.
        align();
        obs_q.delete();
        ready = 1'b0;
        send_slot(LR_LEFT, 32'hAAAAAA00, 24, -1);
        send_slot(LR_RIGHT, 32'hBBBBBB00, 24, -1);
        send_slot(LR_LEFT, 32'hCCCCCC00, 24, -1);
        chk("ovr_valid1", 48'(valid), 48'h1);
        chk("ovr_data1", {data_l, data_r}, 48'hAAAAAA_BBBBBB);
        chk("ovr_flag0", 48'(overrun), 48'h0);
        send_slot(LR_RIGHT, 32'hDDDDDD00, 24, -1);
        flush(0);
        repeat (8) @(negedge clk);
        chk("ovr_valid2", 48'(valid), 48'h1);
        chk("ovr_data2", {data_l, data_r}, 48'hAAAAAA_BBBBBB);
        chk("ovr_flag1", 48'(overrun), 48'h1);
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        chk("ovr_valid_drop", 48'(valid), 48'h0);
        repeat (20) @(negedge clk);
        chk("ovr_no_second", 48'(valid), 48'h0);
        chk("ovr_hs_count", 48'(obs_q.size()), 48'h1);
        chk_frame("ovr_hs_frame", 0, 24'hAAAAAA, 24'hBBBBBB);
        @(posedge clk);
        #1 ready = 1'b1;

        // Reset in the middle of a right slot: partial frame lost, next frames clean.
        align();
        send_slot(LR_LEFT, 32'h13579B00, 24, -1);
        send_slot(LR_RIGHT, 32'h2468AC00, 24, 10);
        send_slot(LR_LEFT, 32'h0F0F0F00, 24, -1);
        send_slot(LR_RIGHT, 32'hF0F0F000, 24, -1);
        send_slot(LR_LEFT, 32'h11223300, 24, -1);
        send_slot(LR_RIGHT, 32'h44556600, 24, -1);
        flush(0);
        wait_obs(2, "rst_count");
        chk_frame("rst_frame0", 0, 24'h0F0F0F, 24'hF0F0F0);
        chk_frame("rst_frame1", 1, 24'h112233, 24'h445566);
        chk("rst_relocked", 48'(locked), 48'h1);

        // Handshake in the same cycle a new frame is emitted.
        align();
        obs_q.delete();
        @(posedge clk);
        #1 ready = 1'b0;
        align();
        send_slot(LR_LEFT, 32'h01020300, 24, -1);
        send_slot(LR_RIGHT, 32'h04050600, 24, -1);
        send_slot(LR_LEFT, 32'h0A0B0C00, 24, -1);
        send_slot(LR_RIGHT, 32'h0D0E0F00, 24, -1);
        flush(2);
        chk("same_valid", 48'(valid), 48'h1);
        chk("same_data", {data_l, data_r}, 48'h0A0B0C_0D0E0F);
        chk("same_overrun", 48'(overrun), 48'h0);
        @(posedge clk);
        #1 ready = 1'b1;
        wait_obs(2, "same_count");
        chk_frame("same_frame0", 0, 24'h010203, 24'h040506);
        chk_frame("same_frame1", 1, 24'h0A0B0C, 24'h0D0E0F);

        // Random slot lengths and data, capture starting inside a right slot.
        align();
        rnd_ready = 1'b1;
        send_slot(LR_RIGHT, $urandom, 32, $urandom_range(2, 20));
        for (int k = 0; k < 20; k++) begin
            send_slot(LR_LEFT, $urandom, $urandom_range(2, 32), -1);
            send_slot(LR_RIGHT, $urandom, $urandom_range(2, 32), -1);
        end
        flush(0);
        wait_obs(20, "rand_count");
        for (int i = 0; i < exp_q.size(); i++) chk_frame($sformatf("rand_frame%0d", i), i, exp_q[i][2*W-1:W], exp_q[i][W-1:0]);
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 ready = 1'b1;
        chk("rand_overrun", 48'(overrun), 48'h0);
        chk("rand_locked", 48'(locked), 48'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
